// File: rtl/bcd_display_ctrl_pkg.sv
// bcd_display_ctrl_pkg: shared widths, limits and FSM encoding for the BCD display controller
package bcd_display_ctrl_pkg;
  localparam int VALUE_W = 14;
  localparam int NDIGITS = 4;
  localparam int MAX_DEC = 9999;
  localparam int CNT_W = 4;
  localparam logic [4*NDIGITS-1:0] DIGITS_MAX = 16'h9999;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 to any BCD nibble of 5 or more
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl: 14-bit binary to 4-digit BCD converter with a multiplexed, optionally zero-blanked display scan
module bcd_display_ctrl
  import bcd_display_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [VALUE_W-1:0] value,
  output logic               in_ready,
  output logic               done,
  output logic               ovf,
  output logic [3:0]         A,
  output logic [3:0]         B,
  output logic [3:0]         C,
  output logic [3:0]         D,
  output logic [NDIGITS-1:0] an_n,
  output logic [3:0]         digit
);
  state_t state_q, state_d;
  logic [VALUE_W-1:0] sr_q, sr_d;
  logic [4*NDIGITS-1:0] acc_q, acc_d, acc_adj, digits_q, digits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic big_q, big_d, ovf_q, ovf_d, done_q, done_d, rdy_q, rdy_d;
  logic [15:0] presc_q, presc_d;
  logic [1:0] slot_q, slot_d;
  logic wrap, blank;
  for (genvar i = 0; i < NDIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (.din(acc_q[4*i +: 4]), .dout(acc_adj[4*i +: 4]));
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;
  // FSM next state: accept in IDLE, 14 shift steps in CONV, one load cycle in UPDATE
  always_comb begin
    state_d = state_q == IDLE ? (in_valid ? CONV : IDLE) :
              state_q == CONV ? (cnt_q == CNT_W'(VALUE_W - 1) ? UPDATE : CONV) : IDLE;
  end
  // FSM outputs, registered so ready and done rise together on the return to IDLE
  always_comb begin
    rdy_d = state_d == IDLE;
    done_d = state_q == UPDATE;
  end
  // conversion datapath: capture, add-3 and shift, then load the held digits
  always_comb begin
    sr_d = sr_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    big_d = big_q;
    digits_d = digits_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid) begin
      sr_d = value;
      acc_d = '0;
      cnt_d = '0;
      big_d = value > VALUE_W'(MAX_DEC);
    end else if (state_q == CONV) begin
      {acc_d, sr_d} = {acc_adj, sr_q} << 1;
      cnt_d = cnt_q + 1'b1;
    end else if (state_q == UPDATE) begin
      digits_d = big_q ? DIGITS_MAX : acc_q;
      ovf_d = big_q;
    end
  end
  // datapath and output registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sr_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      big_q <= 1'b0;
      digits_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      sr_q <= sr_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      big_q <= big_d;
      digits_q <= digits_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
      rdy_q <= rdy_d;
    end
  // scan prescaler and slot advance, free-running regardless of the FSM
  always_comb begin
    wrap = presc_q == 16'(SCAN_DIV - 1);
    presc_d = wrap ? '0 : presc_q + 16'd1;
    slot_d = wrap ? slot_q + 2'd1 : slot_q;
  end
  // scan registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      presc_q <= '0;
      slot_q <= '0;
    end else begin
      presc_q <= presc_d;
      slot_q <= slot_d;
    end
  // slot decode: a slot is blanked when its digit and all higher digits are zero
  always_comb begin
    digit = digits_q[{slot_q, 2'b00} +: 4];
    blank = BLANK_LZ && slot_q != 2'd0 && (digits_q >> {slot_q, 2'b00}) == '0;
    an_n = blank ? '1 : ~(NDIGITS'(1) << slot_q);
  end
  assign {A, B, C, D} = digits_q;
  assign in_ready = rdy_q;
  assign done = done_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_bcd_display_ctrl.sv
// tb_bcd_display_ctrl: directed and random checks of the converter and display scan against a decimal model
module tb_bcd_display_ctrl;
  logic clk = 1'b0;
  logic rst, in_valid;
  logic [13:0] value;
  logic rdy, done, ovf, rdy0, done0, ovf0;
  logic [3:0] A, B, C, D, A0, B0, C0, D0, an_n, an_n0, digit, digit0;
  int total = 0, bad = 0;
  bit chk_on = 0;
  int m_busy, m_val, m_show, m_edges;
  logic m_ovf, m_done;
  int p10[4] = '{1, 10, 100, 1000};
  always #5 clk = ~clk;
  bcd_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .value(value), .in_ready(rdy), .done(done),
    .ovf(ovf), .A(A), .B(B), .C(C), .D(D), .an_n(an_n), .digit(digit));
  bcd_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .value(value), .in_ready(rdy0), .done(done0),
    .ovf(ovf0), .A(A0), .B(B0), .C(C0), .D(D0), .an_n(an_n0), .digit(digit0));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] bcd_of(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction
  // model: a value is accepted when idle and appears 15 edges later
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_busy <= 0; m_val <= 0; m_show <= 0; m_ovf <= 0; m_done <= 0; m_edges <= 0;
    end else begin
      m_edges <= m_edges + 1;
      m_done <= (m_busy == 1);
      if (m_busy == 0 && in_valid) begin
        m_busy <= 15;
        m_val <= int'(value);
      end else if (m_busy > 0) m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_show <= (m_val > 9999) ? 9999 : m_val;
        m_ovf <= (m_val > 9999);
      end
    end
  // per-cycle comparison of both instances against the model
  always @(posedge clk) begin : cmp
    int s;
    logic [3:0] ea;
    #1;
    if (chk_on) begin
      s = (m_edges / 4) % 4;
      chk("in_ready", rdy, m_busy == 0);
      chk("done", done, m_done);
      chk("ovf", ovf, m_ovf);
      chk("digits", {A, B, C, D}, bcd_of(m_show));
      chk("digits_nb", {A0, B0, C0, D0}, bcd_of(m_show));
      ea = 4'b1111;
      ea[s] = 1'b0;
      chk("an_n_nb", an_n0, ea);
      if (s > 0 && m_show < p10[s]) ea = 4'b1111;
      chk("an_n", an_n, ea);
      chk("digit", digit, (m_show / p10[s]) % 10);
      chk("digit_nb", digit0, (m_show / p10[s]) % 10);
    end
  end
  task automatic conv(input logic [13:0] v, input logic [15:0] ed, input logic eo);
    @(negedge clk);
    in_valid = 1'b1;
    value = v;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("busy_ready", rdy, 0);
      chk("busy_done", done, 0);
      @(negedge clk);
    end
    chk("conv_done", done, 1);
    chk("conv_ready", rdy, 1);
    chk("conv_digits", {A, B, C, D}, ed);
    chk("conv_ovf", ovf, eo);
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask
  initial begin
    int c1110, c1111, cnb[4], c7;
    rst = 1'b0;
    in_valid = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rdy, 1);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_digits", {A, B, C, D}, 0);
    chk("rst_an_n", an_n, 4'b1110);
    rst = 1'b1;
    chk_on = 1;
    @(negedge clk);
    chk("rel_an_n", an_n, 4'b1110);
    chk("rel_digit", digit, 0);
    conv(14'd1234, 16'h1234, 1'b0);
    conv(14'd9999, 16'h9999, 1'b0);
    conv(14'd10000, 16'h9999, 1'b1);
    conv(14'd16383, 16'h9999, 1'b1);
    conv(14'd0, 16'h0000, 1'b0);
    conv(14'd1234, 16'h1234, 1'b0);
    // value changes mid-conversion with in_valid held
    @(negedge clk);
    in_valid = 1'b1;
    value = 14'd42;
    @(negedge clk);
    repeat (5) @(negedge clk);
    value = 14'd77;
    repeat (9) @(negedge clk);
    chk("hold_ready", rdy, 0);
    chk("hold_old", {A, B, C, D}, 16'h1234);
    @(negedge clk);
    chk("held_42", {A, B, C, D}, 16'h0042);
    chk("held_done", done, 1);
    @(negedge clk);
    chk("accept_77", rdy, 0);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    chk("keep_42", {A, B, C, D}, 16'h0042);
    @(negedge clk);
    chk("show_77", {A, B, C, D}, 16'h0077);
    @(negedge clk);
    // reset in the middle of a conversion
    @(negedge clk);
    in_valid = 1'b1;
    value = 14'd500;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", rdy, 1);
    chk("abort_digits", {A, B, C, D}, 0);
    chk("abort_an_n", an_n, 4'b1110);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_done", done, 0);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    value = 14'd500;
    @(negedge clk);
    in_valid = 1'b0;
    chk("reaccept", rdy, 0);
    chk("rel2_an_n", an_n, 4'b1110);
    chk("rel2_digit", digit, 0);
    repeat (15) @(negedge clk);
    chk("show_500", {A, B, C, D}, 16'h0500);
    chk("done_500", done, 1);
    // scan pattern for a single-digit value, blanked and unblanked
    conv(14'd7, 16'h0007, 1'b0);
    c1110 = 0; c1111 = 0; c7 = 0;
    cnb = '{0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an_n == 4'b1110) c1110++;
      if (an_n == 4'b1111) c1111++;
      if (an_n == 4'b1110 && digit == 4'd7) c7++;
      for (int s = 0; s < 4; s++) if (an_n0 == ~(4'b0001 << s)) cnb[s]++;
    end
    chk("scan_1110", c1110, 4);
    chk("scan_1111", c1111, 12);
    chk("scan_digit7", c7, 4);
    for (int s = 0; s < 4; s++) chk("scan_nb", cnb[s], 4);
    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom % 150) != 0;
      in_valid = ($urandom % 3) == 0;
      case ($urandom % 8)
        0: value = 14'd0;
        1: value = 14'd9999;
        2: value = 14'd10000;
        3: value = 14'd16383;
        4: value = 14'($urandom);
        default: value = 14'($urandom % 10000);
      endcase
    end
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_display_ctrl.md
BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 SCAN_DIV, default 50000: clk cycles per digit scan slot; legal range 2..65535.
REQ-002 BLANK_LZ, default 1: 1 = leading-zero digits blanked, 0 = all four digits always lit.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  value offered for conversion.
REQ-006 value  input  14  unsigned binary value to display.
REQ-007 in_ready  output  1  block can accept a value.
REQ-008 done  output  1  one-cycle pulse when new digits are loaded.
REQ-009 ovf  output  1  last accepted value exceeded 9999.
REQ-010 A, B, C, D  output  4 each  held BCD digits: A thousands, B hundreds, C tens, D ones.
REQ-011 an_n  output  4  active-low digit enables: an_n[3]=A … an_n[0]=D.
REQ-012 digit  output  4  BCD nibble of the currently enabled slot.

Function
REQ-013 FSM states IDLE, CONV, UPDATE; in_ready SHALL be 1 only in IDLE.
REQ-014 In IDLE, in_valid=1 on a rising edge SHALL capture value into a 14-bit shift register, clear the 16-bit BCD accumulator and iteration counter, and go to CONV.
REQ-015 In CONV, each cycle SHALL add 3 to every accumulator nibble >=5, then shift {accumulator, shift register} left one bit.
REQ-016 CONV SHALL last exactly 14 cycles (counter 0..13), then go to UPDATE.
REQ-017 In UPDATE, if the captured value >9999, A..D SHALL load 9,9,9,9 and ovf SHALL be 1; otherwise A..D SHALL load the accumulator and ovf SHALL be 0.
REQ-018 done SHALL be 1 for exactly the cycle after the UPDATE edge; the FSM SHALL return to IDLE, so in_ready and done rise together.
REQ-019 Latency: A..D, ovf and done update on the 15th rising edge after the accepting edge.
REQ-020 in_valid while not IDLE SHALL be ignored; the value is not queued.
REQ-021 A..D and ovf SHALL hold between conversions; the display keeps showing old digits during CONV.
REQ-022 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; on wrap, a 2-bit slot counter SHALL advance 0→1→2→3→0.
REQ-023 Slot s SHALL drive an_n[s]=0, all other an_n bits 1, and digit = that slot's nibble (slot 0 = D).
REQ-024 When BLANK_LZ=1, slot s>0 SHALL drive an_n all ones if that digit and every higher digit is 0; slot 0 is never blanked.
REQ-025 Scanning SHALL run continuously, independent of the FSM.

Reset
REQ-026 rst=0 SHALL immediately force: state IDLE, in_ready=1, done=0, ovf=0, A=B=C=D=0, prescaler=0, slot=0, shift register, accumulator and counter = 0.
REQ-027 rst asserted mid-CONV SHALL abort the conversion with no done pulse; after release, the block accepts a value on the first edge.
REQ-028 After release, an_n SHALL be 4'b1110 and digit 0 until the first slot wrap.

Structure
REQ-029 Shared package SHALL hold state encoding, VALUE_W=14, NDIGITS=4, MAX_DEC=9999.
REQ-030 One sub-module, bcd_add3 (4-bit: out = in>=5 ? in+3 : in), SHALL be instantiated 4 times in the CONV datapath.
REQ-031 All outputs SHALL be registered except an_n and digit, which SHALL be decoded from registered slot and digits only.

Verification
REQ-032 Reset, then value=1234 accepted at edge k -> A..D = 1,2,3,4, ovf=0, done=1 after edge k+15, in_ready=0 during k+1..k+15.
REQ-033 value=9999 -> 9,9,9,9, ovf=0; value=10000 and value=16383 -> 9,9,9,9, ovf=1; value=0 -> 0,0,0,0.
REQ-034 Accept 42, then change value to 77 at edge k+5 with in_valid held -> 42 displayed after k+15, and 77 accepted at the first IDLE edge.
REQ-035 Accept 500, then rst=0 at edge k+7 -> outputs at reset values, no done; after release, 500 is accepted again and shown within 15 edges.
REQ-036 SCAN_DIV=4, BLANK_LZ=1, display 7 -> an_n cycles 1110,1111,1111,1111 with 4-cycle slots and digit=7 in slot 0; with BLANK_LZ=0 -> 1110,1101,1011,0111.
